// File: rtl/bp_be_fe_feedback_if.sv
// Backend-to-frontend feedback bus: one-shot redirect plus
// the attaboy valid/yumi stream consumed by the PC generator.
interface bp_be_fe_feedback_if #(
  parameter int vaddr_width_p = 39,
  parameter int branch_metadata_fwd_width_p = 8
);
  logic redirect_v_o;
  logic [vaddr_width_p-1:0] redirect_pc_o;
  logic redirect_br_v_o;
  logic [branch_metadata_fwd_width_p-1:0] redirect_br_metadata_fwd_o;
  logic redirect_br_taken_o;
  logic redirect_br_ntaken_o;
  logic redirect_br_nonbr_o;
  logic attaboy_v_o;
  logic [vaddr_width_p-1:0] attaboy_pc_o;
  logic [branch_metadata_fwd_width_p-1:0] attaboy_br_metadata_fwd_o;
  logic attaboy_taken_o;
  logic attaboy_ntaken_o;
  logic attaboy_yumi_i;

  modport master (
    output redirect_v_o, redirect_pc_o, redirect_br_v_o,
    output redirect_br_metadata_fwd_o, redirect_br_taken_o,
    output redirect_br_ntaken_o, redirect_br_nonbr_o,
    output attaboy_v_o, attaboy_pc_o, attaboy_br_metadata_fwd_o,
    output attaboy_taken_o, attaboy_ntaken_o,
    input attaboy_yumi_i
  );

  modport slave (
    input redirect_v_o, redirect_pc_o, redirect_br_v_o,
    input redirect_br_metadata_fwd_o, redirect_br_taken_o,
    input redirect_br_ntaken_o, redirect_br_nonbr_o,
    input attaboy_v_o, attaboy_pc_o, attaboy_br_metadata_fwd_o,
    input attaboy_taken_o, attaboy_ntaken_o,
    output attaboy_yumi_i
  );
endinterface

// File: rtl/bp_be_fe_feedback.sv
// Turns dual-issue branch resolutions into frontend redirects
// and a FIFO of attaboys. Metadata bit0=is_br, bit1=is_jal, bit2=is_jalr.
module bp_be_fe_feedback #(
  parameter int vaddr_width_p = 39,
  parameter int branch_metadata_fwd_width_p = 8,
  parameter int attaboy_els_p = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic [1:0] res_v_i,
  input  logic [2*vaddr_width_p-1:0] res_pc_i,
  input  logic [2*vaddr_width_p-1:0] res_npc_i,
  input  logic [2*vaddr_width_p-1:0] res_pred_npc_i,
  input  logic [1:0] res_taken_i,
  input  logic [2*branch_metadata_fwd_width_p-1:0] res_metadata_i,
  output logic res_ready_o,
  input  logic cmd_redirect_v_i,
  input  logic [vaddr_width_p-1:0] cmd_redirect_pc_i,
  bp_be_fe_feedback_if.master fe
);
  localparam int va_lp = vaddr_width_p;
  localparam int md_lp = branch_metadata_fwd_width_p;
  localparam int pw_lp = $clog2(attaboy_els_p);
  localparam int cw_lp = $clog2(attaboy_els_p + 1);
  localparam logic [cw_lp-1:0] els_lp = cw_lp'(attaboy_els_p);

  typedef struct packed {
    logic [va_lp-1:0] npc;
    logic [md_lp-1:0] md;
    logic taken;
    logic ntaken;
  } ab_s;

  logic [va_lp-1:0] npc [2];
  logic [va_lp-1:0] pred [2];
  logic [md_lp-1:0] md [2];
  ab_s ent [2];
  logic [1:0] br, ctrl, mis, good;

  // Per-slot decode and classification
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      npc[i]  = res_npc_i[i*va_lp +: va_lp];
      pred[i] = res_pred_npc_i[i*va_lp +: va_lp];
      md[i]   = res_metadata_i[i*md_lp +: md_lp];
      br[i]   = md[i][0];
      ctrl[i] = md[i][0] | md[i][1] | md[i][2];
      mis[i]  = res_v_i[i] & (npc[i] != pred[i]);
      good[i] = res_v_i[i] & ctrl[i] & ~mis[i];
      ent[i]  = '{npc[i], md[i], res_taken_i[i],
                  br[i] & ~res_taken_i[i]};
    end
  end

  logic unused;
  assign unused = ^res_pc_i;

  logic rd_v_n, sel;
  assign sel    = ~mis[0];
  assign rd_v_n = cmd_redirect_v_i | mis[0] | mis[1];

  logic enq0, enq1;
  assign enq0 = ~cmd_redirect_v_i & good[0];
  assign enq1 = ~cmd_redirect_v_i & ~mis[0] & good[1];

  logic rd_v_q, rd_br_v_q, rd_tk_q, rd_ntk_q, rd_nonbr_q;
  logic [va_lp-1:0] rd_pc_q;
  logic [md_lp-1:0] rd_md_q;

  ab_s mem_q [attaboy_els_p];
  logic [pw_lp-1:0] wptr_q, rptr_q, wptr_1, wptr_2, wptr_n;
  logic [cw_lp-1:0] count_q, count_n, free;
  logic ready_q, ab_v, deq, acc0, acc1;

  function automatic logic [pw_lp-1:0] inc(input logic [pw_lp-1:0] p);
    return (p == pw_lp'(attaboy_els_p - 1)) ? '0 : p + pw_lp'(1);
  endfunction

  assign ab_v = (count_q != '0) & ~rd_v_q;
  assign deq  = fe.attaboy_yumi_i & ab_v;

  // Accept writes only into free space; excess entries are dropped
  always_comb begin
    free    = els_lp - count_q + cw_lp'(deq);
    acc0    = enq0 & (free != '0);
    acc1    = enq1 & (free > cw_lp'(acc0));
    wptr_1  = inc(wptr_q);
    wptr_2  = inc(wptr_1);
    wptr_n  = wptr_q;
    if (acc0 & acc1) wptr_n = wptr_2;
    else if (acc0 | acc1) wptr_n = wptr_1;
    count_n = count_q + cw_lp'(acc0) + cw_lp'(acc1) - cw_lp'(deq);
  end

  // Redirect register: valid for exactly one cycle after the cause
  always_ff @(posedge clk_i) begin
    if (reset_i | ~rd_v_n) begin
      rd_v_q     <= 1'b0;
      rd_pc_q    <= '0;
      rd_br_v_q  <= 1'b0;
      rd_md_q    <= '0;
      rd_tk_q    <= 1'b0;
      rd_ntk_q   <= 1'b0;
      rd_nonbr_q <= 1'b0;
    end else if (cmd_redirect_v_i) begin
      rd_v_q     <= 1'b1;
      rd_pc_q    <= cmd_redirect_pc_i;
      rd_br_v_q  <= 1'b0;
      rd_md_q    <= '0;
      rd_tk_q    <= 1'b0;
      rd_ntk_q   <= 1'b0;
      rd_nonbr_q <= 1'b0;
    end else begin
      rd_v_q     <= 1'b1;
      rd_pc_q    <= npc[sel];
      rd_br_v_q  <= 1'b1;
      rd_md_q    <= md[sel];
      rd_tk_q    <= res_taken_i[sel];
      rd_ntk_q   <= br[sel] & ~res_taken_i[sel];
      rd_nonbr_q <= ~ctrl[sel];
    end
  end

  // Attaboy FIFO state: pointers, occupancy, storage, ready flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      for (int i = 0; i < attaboy_els_p; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_n;
      count_q <= count_n;
      ready_q <= (els_lp - count_n) >= cw_lp'(2);
      if (deq) rptr_q <= inc(rptr_q);
      if (acc0) mem_q[wptr_q] <= ent[0];
      if (acc1) mem_q[acc0 ? wptr_1 : wptr_q] <= ent[1];
    end
  end

  assign res_ready_o = ready_q;

  assign fe.redirect_v_o = rd_v_q;
  assign fe.redirect_pc_o = rd_pc_q;
  assign fe.redirect_br_v_o = rd_br_v_q;
  assign fe.redirect_br_metadata_fwd_o = rd_md_q;
  assign fe.redirect_br_taken_o = rd_tk_q;
  assign fe.redirect_br_ntaken_o = rd_ntk_q;
  assign fe.redirect_br_nonbr_o = rd_nonbr_q;

  assign fe.attaboy_v_o = ab_v;
  assign fe.attaboy_pc_o = mem_q[rptr_q].npc;
  assign fe.attaboy_br_metadata_fwd_o = mem_q[rptr_q].md;
  assign fe.attaboy_taken_o = mem_q[rptr_q].taken;
  assign fe.attaboy_ntaken_o = mem_q[rptr_q].ntaken;
endmodule

// File: tb/tb_bp_be_fe_feedback.sv
// Directed bench for bp_be_fe_feedback: redirects, squash,
// attaboy ordering, back-pressure, pointer wrap, mid-run reset.
module tb_bp_be_fe_feedback;
  localparam int VA = 39;
  localparam int MD = 8;

  logic clk = 1'b0;
  logic reset_i;
  logic [1:0] res_v_i;
  logic [2*VA-1:0] res_pc_i, res_npc_i, res_pred_npc_i;
  logic [1:0] res_taken_i;
  logic [2*MD-1:0] res_metadata_i;
  logic res_ready_o;
  logic cmd_redirect_v_i;
  logic [VA-1:0] cmd_redirect_pc_i;

  int n_chk = 0;
  int n_err = 0;

  bp_be_fe_feedback_if #(
    .vaddr_width_p(VA),
    .branch_metadata_fwd_width_p(MD)
  ) fb ();

  bp_be_fe_feedback #(
    .vaddr_width_p(VA),
    .branch_metadata_fwd_width_p(MD),
    .attaboy_els_p(4)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .res_v_i(res_v_i),
    .res_pc_i(res_pc_i),
    .res_npc_i(res_npc_i),
    .res_pred_npc_i(res_pred_npc_i),
    .res_taken_i(res_taken_i),
    .res_metadata_i(res_metadata_i),
    .res_ready_o(res_ready_o),
    .cmd_redirect_v_i(cmd_redirect_v_i),
    .cmd_redirect_pc_i(cmd_redirect_pc_i),
    .fe(fb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset_i) begin
      assert (!(fb.attaboy_yumi_i && !fb.attaboy_v_o))
        else $error("FAIL yumi_illegal v=%0b", fb.attaboy_v_o);
      assert (!(|res_v_i && !res_ready_o))
        else $error("FAIL res_v_not_ready v=%0b", res_v_i);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    res_v_i = '0;
    res_pc_i = '0;
    res_npc_i = '0;
    res_pred_npc_i = '0;
    res_taken_i = '0;
    res_metadata_i = '0;
    cmd_redirect_v_i = 1'b0;
    cmd_redirect_pc_i = '0;
    fb.attaboy_yumi_i = 1'b0;
  endtask

  task automatic slot(input int i, input logic [VA-1:0] np,
                      input logic [VA-1:0] pp, input logic tk,
                      input logic [MD-1:0] m);
    res_v_i[i] = 1'b1;
    res_pc_i[i*VA +: VA] = np - VA'(4);
    res_npc_i[i*VA +: VA] = np;
    res_pred_npc_i[i*VA +: VA] = pp;
    res_taken_i[i] = tk;
    res_metadata_i[i*MD +: MD] = m;
  endtask

  task automatic chk_rd(input string tag, input logic [VA-1:0] pc,
                        input logic bv, input logic tk,
                        input logic ntk, input logic nb,
                        input logic [MD-1:0] m);
    chk({tag, "_v"}, fb.redirect_v_o, 1'b1);
    chk({tag, "_pc"}, fb.redirect_pc_o, pc);
    chk({tag, "_brv"}, fb.redirect_br_v_o, bv);
    chk({tag, "_tk"}, fb.redirect_br_taken_o, tk);
    chk({tag, "_ntk"}, fb.redirect_br_ntaken_o, ntk);
    chk({tag, "_nonbr"}, fb.redirect_br_nonbr_o, nb);
    chk({tag, "_md"}, fb.redirect_br_metadata_fwd_o, m);
  endtask

  logic [VA-1:0] q[$];
  int n_sent;
  int nenq;

  initial begin
    idle();
    reset_i = 1'b1;
    tick();
    tick();
    chk("rst_ready", res_ready_o, 1'b0);
    chk("rst_rd_v", fb.redirect_v_o, 1'b0);
    chk("rst_rd_pc", fb.redirect_pc_o, 0);
    chk("rst_ab_v", fb.attaboy_v_o, 1'b0);
    chk("rst_ab_pc", fb.attaboy_pc_o, 0);
    reset_i = 1'b0;
    tick();
    chk("post_rst_ready", res_ready_o, 1'b1);

    // taken branch mispredicted
    slot(0, 39'h200, 39'h104, 1'b1, 8'h11);
    tick();
    idle();
    chk_rd("t1", 39'h200, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
    chk("t1_ab_v", fb.attaboy_v_o, 1'b0);
    tick();
    chk("t1_one_cycle", fb.redirect_v_o, 1'b0);
    chk("t1_no_ab", fb.attaboy_v_o, 1'b0);

    // two correct predictions, ordered slot 0 first
    slot(0, 39'h300, 39'h300, 1'b1, 8'h22);
    slot(1, 39'h30c, 39'h30c, 1'b0, 8'h31);
    tick();
    idle();
    chk("t2_rd_v", fb.redirect_v_o, 1'b0);
    chk("t2_ab_v", fb.attaboy_v_o, 1'b1);
    chk("t2_ab_pc", fb.attaboy_pc_o, 39'h300);
    chk("t2_ab_tk", fb.attaboy_taken_o, 1'b1);
    chk("t2_ab_ntk", fb.attaboy_ntaken_o, 1'b0);
    chk("t2_ab_md", fb.attaboy_br_metadata_fwd_o, 8'h22);
    chk("t2_ready", res_ready_o, 1'b1);
    fb.attaboy_yumi_i = 1'b1;
    tick();
    fb.attaboy_yumi_i = 1'b0;
    chk("t2b_ab_v", fb.attaboy_v_o, 1'b1);
    chk("t2b_ab_pc", fb.attaboy_pc_o, 39'h30c);
    chk("t2b_ab_tk", fb.attaboy_taken_o, 1'b0);
    chk("t2b_ab_ntk", fb.attaboy_ntaken_o, 1'b1);
    chk("t2b_ab_md", fb.attaboy_br_metadata_fwd_o, 8'h31);
    fb.attaboy_yumi_i = 1'b1;
    tick();
    fb.attaboy_yumi_i = 1'b0;
    chk("t2_empty", fb.attaboy_v_o, 1'b0);

    // slot 0 mispredict squashes good slot 1
    slot(0, 39'h400, 39'h404, 1'b1, 8'h01);
    slot(1, 39'h500, 39'h500, 1'b1, 8'h01);
    tick();
    idle();
    chk_rd("t3", 39'h400, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01);
    tick();
    chk("t3_no_ab", fb.attaboy_v_o, 1'b0);
    chk("t3_ready", res_ready_o, 1'b1);

    // non-control instruction mispredicted
    slot(0, 39'h14, 39'h50, 1'b0, 8'h40);
    tick();
    idle();
    chk_rd("t4", 39'h14, 1'b1, 1'b0, 1'b0, 1'b1, 8'h40);

    // command redirect beats branch mispredict
    cmd_redirect_v_i = 1'b1;
    cmd_redirect_pc_i = 39'h8000;
    slot(0, 39'h900, 39'h904, 1'b1, 8'h01);
    tick();
    idle();
    chk_rd("t5", 39'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    chk("t5_no_ab", fb.attaboy_v_o, 1'b0);

    // command redirect discards a good slot too
    cmd_redirect_v_i = 1'b1;
    cmd_redirect_pc_i = 39'h8100;
    slot(0, 39'ha00, 39'ha00, 1'b1, 8'h02);
    tick();
    idle();
    chk("t5b_pc", fb.redirect_pc_o, 39'h8100);
    tick();
    chk("t5b_no_ab", fb.attaboy_v_o, 1'b0);

    // fill to 3, check back-pressure
    slot(0, 39'h1000, 39'h1000, 1'b0, 8'h01);
    tick();
    idle();
    chk("t6_rdy1", res_ready_o, 1'b1);
    slot(0, 39'h1004, 39'h1004, 1'b0, 8'h01);
    slot(1, 39'h1008, 39'h1008, 1'b0, 8'h01);
    tick();
    idle();
    chk("t6_rdy3", res_ready_o, 1'b0);
    q = '{39'h1000, 39'h1004, 39'h1008};
    n_sent = 3;
    cmd_redirect_v_i = 1'b1;
    cmd_redirect_pc_i = 39'h7000;
    tick();
    idle();
    chk("t6_rd_v", fb.redirect_v_o, 1'b1);
    chk("t6_rd_pc", fb.redirect_pc_o, 39'h7000);
    chk("t6_ab_hidden", fb.attaboy_v_o, 1'b0);
    tick();

    // drain and refill across pointer wrap, 10 entries total
    for (int cyc = 0; cyc < 40 && (n_sent < 10 || q.size() != 0);
         cyc++) begin
      chk("wrap_v", fb.attaboy_v_o, q.size() != 0);
      chk("wrap_rdy", res_ready_o, (4 - q.size()) >= 2);
      if (q.size() != 0) chk("wrap_pc", fb.attaboy_pc_o, q[0]);
      fb.attaboy_yumi_i = (q.size() != 0);
      nenq = 0;
      if ((4 - q.size()) >= 2)
        nenq = (10 - n_sent) < 2 ? 10 - n_sent : 2;
      for (int k = 0; k < nenq; k++) begin
        slot(k, VA'(39'h1000 + 4 * n_sent), VA'(39'h1000 + 4 * n_sent),
             1'b0, 8'h01);
        q.push_back(VA'(39'h1000 + 4 * n_sent));
        n_sent++;
      end
      tick();
      if (fb.attaboy_yumi_i) void'(q.pop_front());
      idle();
    end
    chk("wrap_done", fb.attaboy_v_o, 1'b0);

    // good slot 0 enqueued, slot 1 jalr redirects
    slot(0, 39'h2004, 39'h2004, 1'b0, 8'h01);
    slot(1, 39'h2100, 39'h2200, 1'b1, 8'h04);
    tick();
    idle();
    chk_rd("t7", 39'h2100, 1'b1, 1'b1, 1'b0, 1'b0, 8'h04);
    chk("t7_ab_hidden", fb.attaboy_v_o, 1'b0);
    tick();
    chk("t7_ab_v", fb.attaboy_v_o, 1'b1);
    chk("t7_ab_pc", fb.attaboy_pc_o, 39'h2004);
    chk("t7_ab_ntk", fb.attaboy_ntaken_o, 1'b1);

    // reset mid-operation with an attaboy and a redirect pending
    slot(0, 39'h3100, 39'h3104, 1'b1, 8'h01);
    tick();
    idle();
    chk("t8_rd_v", fb.redirect_v_o, 1'b1);
    reset_i = 1'b1;
    tick();
    chk("t8_rst_rd_v", fb.redirect_v_o, 1'b0);
    chk("t8_rst_ab_v", fb.attaboy_v_o, 1'b0);
    chk("t8_rst_ready", res_ready_o, 1'b0);
    reset_i = 1'b0;
    tick();
    chk("t8_ready", res_ready_o, 1'b1);
    chk("t8_empty", fb.attaboy_v_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
